// File: rtl/alu_seq.sv
// Handshaked sequential ALU: binary/BCD add-subtract, logic ops, inc/dec and
// multi-cycle shift/rotate by count, with an internal {N,V,Z,C} flag register.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter int SHAMT_W    = 3,
  parameter int DECIMAL_EN = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               decimal,
  input  logic               flags_load,
  input  logic [3:0]         flags_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   f,
  output logic [3:0]         flags,
  output logic               busy
);

  localparam int MSB = WIDTH - 1;
  localparam int NIB = WIDTH / 4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_f;
  logic [3:0]         r_flags;   // {N,V,Z,C}
  logic [WIDTH-1:0]   r_work;
  logic               r_wc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;

  logic               w_is_shift;
  logic               w_dec;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_bcd_add;
  logic [WIDTH-1:0]   w_bcd_sub;
  logic [4:0]         w_t_add;
  logic [4:0]         w_t_sub;
  logic               w_dc;
  logic               w_db;
  logic [WIDTH-1:0]   w_imm_f;
  logic [3:0]         w_imm_flags;
  logic               w_upd_nz;
  logic [WIDTH-1:0]   w_step;
  logic               w_step_c;

  assign w_is_shift = (op >= 4'd7) && (op <= 4'd10);
  assign w_dec      = (DECIMAL_EN != 0) && decimal;
  assign w_sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_flags[0]};
  assign w_diff     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, !r_flags[0]};

  assign f     = r_f;
  assign flags = r_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = !flags_load;
        if (in_valid && !flags_load)
          w_state_next = (w_is_shift && (shamt != '0)) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Nibble-serial BCD correction; the final carry/borrow becomes the decimal C.
  always_comb begin
    w_bcd_add = '0;
    w_bcd_sub = '0;
    w_t_add   = '0;
    w_t_sub   = '0;
    w_dc      = r_flags[0];
    w_db      = !r_flags[0];
    for (int i = 0; i < NIB; i++) begin
      w_t_add = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, w_dc};
      w_dc    = (w_t_add > 5'd9);
      w_bcd_add[4*i +: 4] = w_dc ? (w_t_add[3:0] + 4'd6) : w_t_add[3:0];
      w_t_sub = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, w_db};
      w_db    = w_t_sub[4];
      w_bcd_sub[4*i +: 4] = w_db ? (w_t_sub[3:0] - 4'd6) : w_t_sub[3:0];
    end
  end

  always_comb begin
    w_imm_f     = a;
    w_imm_flags = r_flags;
    w_upd_nz    = 1'b1;
    case (op)
      4'd0: begin
        w_imm_f        = w_dec ? w_bcd_add : w_sum[MSB:0];
        w_imm_flags[0] = w_dec ? w_dc : w_sum[WIDTH];
        w_imm_flags[2] = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      4'd1: begin
        w_imm_f        = w_dec ? w_bcd_sub : w_diff[MSB:0];
        w_imm_flags[0] = w_dec ? !w_db : !w_diff[WIDTH];
        w_imm_flags[2] = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      4'd2:  w_imm_f = a ^ b;
      4'd3:  w_imm_f = a | b;
      4'd4:  w_imm_f = a & b;
      4'd5:  w_imm_f = a + WIDTH'(1);
      4'd6:  w_imm_f = a - WIDTH'(1);
      // Only reached with a zero count: result is b, C untouched.
      4'd7, 4'd8, 4'd9, 4'd10: w_imm_f = b;
      default: w_upd_nz = 1'b0;
    endcase
    if (w_upd_nz) begin
      w_imm_flags[3] = w_imm_f[MSB];
      w_imm_flags[1] = (w_imm_f == '0);
    end
  end

  always_comb begin
    w_step   = r_work;
    w_step_c = r_wc;
    case (r_op)
      4'd7: begin
        w_step   = {r_wc, r_work[MSB:1]};
        w_step_c = r_work[0];
      end
      4'd8: begin
        w_step   = {r_work[MSB-1:0], r_wc};
        w_step_c = r_work[MSB];
      end
      4'd9: begin
        w_step   = {r_work[MSB-1:0], 1'b0};
        w_step_c = r_work[MSB];
      end
      4'd10: begin
        w_step   = {1'b0, r_work[MSB:1]};
        w_step_c = r_work[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f     <= '0;
      r_flags <= '0;
      r_work  <= '0;
      r_wc    <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flags_load) begin
            r_flags <= flags_in;
          end else if (in_valid) begin
            if (w_is_shift && (shamt != '0)) begin
              r_work <= b;
              r_wc   <= r_flags[0];
              r_cnt  <= shamt;
              r_op   <= op;
            end else begin
              r_f     <= w_imm_f;
              r_flags <= w_imm_flags;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_step;
          r_wc   <= w_step_c;
          r_cnt  <= r_cnt - SHAMT_W'(1);
          // Last step publishes the result; V is never touched by shifts.
          if (r_cnt == SHAMT_W'(1)) begin
            r_f     <= w_step;
            r_flags <= {w_step[MSB], r_flags[2], (w_step == '0), w_step_c};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a
// monitor pops and compares on every output handshake.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [SW-1:0] shamt = '0;
  logic          decimal = 1'b0;
  logic          flags_load = 1'b0;
  logic [3:0]    flags_in = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  f;
  logic [3:0]    flags;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic [W+3:0] exp_q[$];
  logic [W+3:0] mon_exp;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHAMT_W(SW), .DECIMAL_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt), .decimal(decimal),
    .flags_load(flags_load), .flags_in(flags_in), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .flags(flags), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      txn++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got f=%h flags=%b expected none", f, flags);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("txn %0d: f=%h flags=%b expected f=%h flags=%b",
                 txn, f, flags, mon_exp[W+3:4], mon_exp[3:0]);
        chk("result_f", 32'(f), 32'(mon_exp[W+3:4]));
        chk("result_flags", 32'(flags), 32'(mon_exp[3:0]));
      end
    end
  end

  task automatic load_flags(input logic [3:0] v);
    @(negedge clk);
    flags_load = 1'b1;
    flags_in   = v;
    in_valid   = 1'b1;
    #1 chk("in_ready_during_load", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 flags_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flags_loaded", 32'(flags), 32'(v));
    chk("no_accept_during_load", 32'(busy), 32'(0));
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [SW-1:0] sh, input logic dec,
                        input logic [W-1:0] ef, input logic [3:0] efl, input int lat);
    @(negedge clk);
    op = o; a = av; b = bv; shamt = sh; decimal = dec; in_valid = 1'b1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'(1));
    exp_q.push_back({ef, efl});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      chk({name, "_out_valid"}, 32'(out_valid), 32'(j == lat));
      chk({name, "_busy"}, 32'(busy), 32'(1));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_f", 32'(f), 32'(0));
    chk("rst_flags", 32'(flags), 32'(0));
    reset_n = 1'b1;

    load_flags(4'b0001);
    run_op("adc_ovf", 4'd0, 8'h50, 8'h50, 3'd0, 1'b0, 8'hA1, 4'b1100, 1);
    load_flags(4'b0001);
    run_op("sbc_borrow", 4'd1, 8'h00, 8'h01, 3'd0, 1'b0, 8'hFF, 4'b1000, 1);
    load_flags(4'b0001);
    run_op("sbc_ovf", 4'd1, 8'h80, 8'h01, 3'd0, 1'b0, 8'h7F, 4'b0101, 1);
    load_flags(4'b0000);
    run_op("rol3", 4'd8, 8'h00, 8'h81, 3'd3, 1'b0, 8'h0A, 4'b0000, 4);
    run_op("asl0", 4'd9, 8'h77, 8'h01, 3'd0, 1'b0, 8'h01, 4'b0000, 1);
    run_op("lsr1", 4'd10, 8'h00, 8'h81, 3'd1, 1'b0, 8'h40, 4'b0001, 2);
    run_op("ror2", 4'd7, 8'h00, 8'h01, 3'd2, 1'b0, 8'hC0, 4'b1000, 3);
    run_op("eor_zero", 4'd2, 8'hFF, 8'hFF, 3'd0, 1'b0, 8'h00, 4'b0010, 1);
    run_op("inc_wrap", 4'd5, 8'hFF, 8'h00, 3'd0, 1'b0, 8'h00, 4'b0010, 1);
    run_op("dec_wrap", 4'd6, 8'h00, 8'h00, 3'd0, 1'b0, 8'hFF, 4'b1000, 1);
    run_op("pass_a", 4'd15, 8'h00, 8'h12, 3'd0, 1'b0, 8'h00, 4'b1000, 1);

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    op = 4'd3; a = 8'h0F; b = 8'hF0; shamt = 3'd0; decimal = 1'b0; in_valid = 1'b1;
    exp_q.push_back({8'hFF, 4'b1000});
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'(1));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
      chk("hold_f", 32'(f), 32'(8'hFF));
      chk("hold_flags", 32'(flags), 32'(4'b1000));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'(1));
    chk("release_out_valid", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_double_accept", 32'(busy), 32'(0));

    run_op("and", 4'd4, 8'hF0, 8'h3C, 3'd0, 1'b0, 8'h30, 4'b0000, 1);

    load_flags(4'b0000);
    run_op("bcd_adc", 4'd0, 8'h19, 8'h28, 3'd0, 1'b1, 8'h47, 4'b0000, 1);
    run_op("bcd_adc_carry", 4'd0, 8'h99, 8'h01, 3'd0, 1'b1, 8'h00, 4'b0011, 1);
    run_op("bcd_sbc", 4'd1, 8'h10, 8'h01, 3'd0, 1'b1, 8'h09, 4'b0001, 1);

    // Abort a long rotate with reset: no result may appear.
    @(negedge clk);
    op = 4'd8; a = 8'h00; b = 8'h55; shamt = 3'd7; decimal = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("shift_busy", 32'(busy), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_flags", 32'(flags), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_f", 32'(f), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_op("adc_after_rst", 4'd0, 8'h01, 8'h02, 3'd0, 1'b0, 8'h03, 4'b0000, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the CPU's combinational ALU.
- Implements the same op set: ADC, SBC, EOR, ORA, AND, INC, DEC, ROR, ROL, ASL, LSR and pass-A.
- Adds an internal N/V/Z/C flag register, multi-bit shift/rotate by count (one bit per cycle), optional BCD add/subtract, and valid/ready handshakes on input and output.
- Sits between the control unit (operand and opcode issue) and the register file/status register.

Parameters:
- WIDTH, 8, operand and result width in bits (≥4).
- SHAMT_W, 3, width of the shift-count input.
- DECIMAL_EN, 0, 1 enables BCD ADC/SBC. Requires WIDTH to be a multiple of 4.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  operation: 0 ADC, 1 SBC, 2 EOR, 3 ORA, 4 AND, 5 INC, 6 DEC, 7 ROR, 8 ROL, 9 ASL, A LSR, others pass A.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. Shift/rotate operand.
- shamt  in  SHAMT_W  shift/rotate count.
- decimal  in  1  BCD mode for ADC/SBC. Ignored when DECIMAL_EN=0.
- flags_load  in  1  load flag register from flags_in.
- flags_in  in  4  {N,V,Z,C} load value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  registered result.
- flags  out  4  registered {N,V,Z,C}.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, f=0, flags=0, out_valid=0, busy=0, in_ready=1. An assertion mid-operation aborts the operation immediately; no result is produced.
- State machine: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !flags_load. A request is accepted on a clock edge with in_valid && in_ready; a, b, op, shamt and decimal are captured at that edge.
- flags_load is honoured only in IDLE. It has priority over accept; no request is accepted in that cycle. Outside IDLE it is ignored.
- Ops 0–6 and pass-A: IDLE → DONE. out_valid is high the cycle after accept (latency 1).
- Ops 7–A, shamt=N≥1: IDLE → SHIFT. One bit position per cycle for N cycles, then → DONE. out_valid rises N+1 cycles after accept. The working register starts at b. Rotates shift through C; each step's shifted-out bit becomes the new C. ASL fills with 0 at the LSB; LSR fills with 0 at the MSB.
- shamt=0 on ops 7–A: IDLE → DONE with f=b and C unchanged.
- DONE: f and flags are held stable while out_ready is low. On out_valid && out_ready → IDLE. No new accept occurs in that same cycle.
- Arithmetic: all results are modulo 2^WIDTH; the carry-in is the C flag.
  - ADC: f=a+b+C. C=carry out. V = (a[msb]==b[msb]) && (f[msb]!=a[msb]).
  - SBC: f=a-b-!C. C=1 if no borrow. V = (a[msb]!=b[msb]) && (f[msb]!=a[msb]).
  - INC/DEC wrap: all-ones+1=0, 0-1=all-ones.
- Decimal (DECIMAL_EN && decimal, ADC/SBC only): per-nibble BCD correction. C is the decimal carry/no-borrow. V uses the binary formula. Non-BCD inputs give an unspecified f, but flags must still update deterministically.
- Flag update when entering DONE:
  - N=f[msb] and Z=(f==0) for every op except pass-A, which leaves all flags unchanged.
  - C: updated by ADC, SBC and shifts/rotates; unchanged by the others.
  - V: updated by ADC and SBC only.
  - Flags are not updated during intermediate SHIFT cycles, apart from the internal working C.
- busy = (state!=IDLE).

Test Plan:
- Reset; flags_load=1 with flags_in=4'b0001; then ADC a=0x50 b=0x50 → f=0x51+0x50=0xA1, flags N=1 V=1 Z=0 C=0, out_valid exactly 1 cycle after accept.
- flags C=1; SBC a=0x00 b=0x01 → f=0xFF, N=1, C=0, V=0. Then SBC a=0x80 b=0x01 with C=1 → f=0x7F, V=1, C=1.
- C=0; ROL b=0x81 shamt=3 → f=0x0A, C=0. out_valid 4 cycles after accept, busy high for those 4 cycles. ASL b=0x01 shamt=0 → f=0x01, 1-cycle latency.
- Hold out_ready=0 for 5 cycles after a result → f, flags and out_valid stable and in_ready=0. Assert out_ready → IDLE next cycle, in_ready=1. in_valid held high throughout causes no double accept.
- DECIMAL_EN=1, decimal=1, C=0: ADC 0x19+0x28 → 0x47, C=0. ADC 0x99+0x01 → 0x00, C=1, Z=1. SBC 0x10-0x01 with C=1 → 0x09, C=1.
- Assert reset_n low during SHIFT (shamt=7) → out_valid=0, flags=0, busy=0, in_ready=1 asynchronously. After release, a new ADC completes normally.
